// File: rtl/draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : draw_pkg                                               |
// | Description : Shared defaults, instruction-width helper and the      |
// |               sequencer state encoding for the draw pipeline.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package draw_pkg;

  // Default draw-instruction field widths
  localparam int C_DEF_WIDTH    = 4;
  localparam int C_DEF_HEIGHT   = 3;
  localparam int C_DEF_MISC_AMT = 9;
  localparam int C_DEF_OP_SIZE  = 1;

  // Packed instruction width: three (x,y) coordinate pairs, 25 bits of
  // shape/colour fields, the op-code and the misc amount.
  function automatic int instr_w(input int width, input int height,
                                 input int misc_amt, input int op_size);
    return 3 * (width + height) + 25 + op_size + misc_amt;
  endfunction

  // Sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_ISSUE     = 2'd1,
    SEQ_WAIT_DONE = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instr_fifo                                             |
// | Description : Power-of-two deep instruction queue with flush.        |
// |               Flush wins over push and pop in the same cycle.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module instr_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 56,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  // Next-state for pointers, occupancy and storage; pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : draw_sequencer                                         |
// | Description : Queues draw instructions and hands them one at a time  |
// |               to the draw engine (IDLE -> ISSUE -> WAIT_DONE).       |
// |               Optional macro DRAW_SEQ_STATS_EN adds a 16-bit         |
// |               issued_count output.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module draw_sequencer
  import draw_pkg::*;
#(
  parameter  int WIDTH    = C_DEF_WIDTH,
  parameter  int HEIGHT   = C_DEF_HEIGHT,
  parameter  int MISC_AMT = C_DEF_MISC_AMT,
  parameter  int OP_SIZE  = C_DEF_OP_SIZE,
  parameter  int DEPTH    = 4,
  localparam int INSTR_W  = instr_w(WIDTH, HEIGHT, MISC_AMT, OP_SIZE),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               eng_start,
  output logic [INSTR_W-1:0] eng_instr,
  input  logic               eng_done,
  output logic               busy,
  output logic [CNT_W-1:0]   fifo_count
`ifdef DRAW_SEQ_STATS_EN
  ,
  output logic [15:0]        issued_count
`endif
);

  seq_state_e         state_q, state_d;
  logic [INSTR_W-1:0] eng_instr_q, eng_instr_d;
  logic [INSTR_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_pop;
  logic               fifo_push;

  // Readiness depends only on occupancy and flush, never on a same-cycle pop
  assign in_ready  = !fifo_full && !flush;
  assign fifo_push = in_valid && in_ready;
  assign eng_start = (state_q == SEQ_ISSUE);
  assign busy      = (state_q != SEQ_IDLE);
  assign eng_instr = eng_instr_q;

  instr_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (in_instr),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Sequencer FSM: pop into the instruction register on IDLE->ISSUE only
  always_comb begin
    state_d     = state_q;
    eng_instr_d = eng_instr_q;
    fifo_pop    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if ((fifo_count != '0) && !flush) begin
          fifo_pop    = 1'b1;
          eng_instr_d = fifo_dout;
          state_d     = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        state_d = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        if (eng_done) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // FSM state and held instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      eng_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      eng_instr_q <= eng_instr_d;
    end
  end

`ifdef DRAW_SEQ_STATS_EN
  logic [15:0] issued_count_q, issued_count_d;

  // Free-running issue counter, wraps at 16 bits
  always_comb begin
    issued_count_d = issued_count_q + 16'(eng_start);
  end

  // Issue counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_count_q <= '0;
    end else begin
      issued_count_q <= issued_count_d;
    end
  end

  assign issued_count = issued_count_q;
`endif

endmodule
`default_nettype wire
